// File: rtl/tt_ctrl_pkg.sv
// Shared types and constants for the project-mux control sequencer.
// Provides the FSM state enum, default timings and a counter-width helper.
package tt_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DISABLE,
        SELRST,
        INC_HI,
        INC_LO,
        ENABLE
    } state_t;

    localparam int PULSE_CYCLES_DEF  = 2;
    localparam int SETTLE_CYCLES_DEF = 4;

    // Bits needed to hold values 0 .. max_val-1.
    function automatic int cnt_width(input int max_val);
        return (max_val > 1) ? $clog2(max_val) : 1;
    endfunction

endpackage

// File: rtl/tt_ctrl_pulse_timer.sv
// Loadable down-counter with a done flag, shared by every timed FSM state.
// Ports: clk, rst (async, active-high), load/load_val, count, done (count==0).
module tt_ctrl_pulse_timer #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         done
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/tt_ctrl_sequencer.sv
// Replays the project-mux selection protocol (disable, reset, N increments,
// re-enable) on ctrl_ena / ctrl_sel_inc / ctrl_sel_rst_n for each request.
// Ports: clk, rst (async, active-high); req_valid/req_ready/req_addr request;
// busy, err, cur_addr, cur_valid status; ctrl_* registered pad outputs.
// Optional macro TT_CTRL_INCREMENTAL_EN: step forward from the current
// selection without resetting the selector when the target is not below it.
module tt_ctrl_sequencer
    import tt_ctrl_pkg::*;
#(
    parameter int ADDR_W        = 10,
    parameter int MAX_ADDR      = 1023,
    parameter int PULSE_CYCLES  = PULSE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              busy,
    output logic              err,
    output logic [ADDR_W-1:0] cur_addr,
    output logic              cur_valid,
    output logic              ctrl_ena,
    output logic              ctrl_sel_inc,
    output logic              ctrl_sel_rst_n
);

    // SELRST spans two pulse phases, so the timer must hold 2*PULSE-1.
    localparam int TMAX = (2 * PULSE_CYCLES > SETTLE_CYCLES) ?
                          2 * PULSE_CYCLES : SETTLE_CYCLES;
    localparam int CW = cnt_width(TMAX);

    localparam logic [CW-1:0] T_PULSE  = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] T_SELRST = CW'(2 * PULSE_CYCLES - 1);
    localparam logic [CW-1:0] T_SETTLE = CW'(SETTLE_CYCLES - 1);
    localparam logic [CW-1:0] T_MID    = CW'(PULSE_CYCLES);
    localparam logic [ADDR_W:0] MAX_EXT = (ADDR_W + 1)'(MAX_ADDR);

    state_t            state;
    logic [ADDR_W-1:0] tgt;
    logic [ADDR_W-1:0] n_cnt;
    logic              skip;
    logic [CW-1:0]     t_cnt;
    logic [CW-1:0]     t_val;
    logic [CW-1:0]     t_first;
    logic              t_done;
    logic              t_load;
    logic              accept;
    logic              bad;

    assign accept  = req_valid & req_ready;
    assign bad     = {1'b0, req_addr} > MAX_EXT;
    // Length of the state entered after reset/disable: pulses or straight to enable.
    assign t_first = (n_cnt == '0) ? T_SETTLE : T_PULSE;

    always_comb begin
        t_load = 1'b0;
        t_val  = T_SETTLE;
        unique case (state)
            IDLE:    t_load = accept & ~bad;
            DISABLE: begin
                t_load = t_done;
                t_val  = skip ? t_first : T_SELRST;
            end
            SELRST:  begin
                t_load = t_done;
                t_val  = t_first;
            end
            INC_HI:  begin
                t_load = t_done;
                t_val  = T_PULSE;
            end
            INC_LO:  begin
                t_load = t_done;
                t_val  = t_first;
            end
            ENABLE:  t_load = 1'b0;
            default: t_load = 1'b0;
        endcase
    end

    tt_ctrl_pulse_timer #(.W(CW)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (t_load),
        .load_val (t_val),
        .count    (t_cnt),
        .done     (t_done)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            req_ready      <= 1'b0;
            busy           <= 1'b0;
            err            <= 1'b0;
            cur_addr       <= '0;
            cur_valid      <= 1'b0;
            ctrl_ena       <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            tgt            <= '0;
            n_cnt          <= '0;
            skip           <= 1'b0;
        end else begin
            err <= 1'b0;
            unique case (state)
                IDLE: begin
                    req_ready <= 1'b1;
                    if (accept) begin
                        if (bad) begin
                            err <= 1'b1;
                        end else begin
                            tgt            <= req_addr;
                            cur_valid      <= 1'b0;
                            busy           <= 1'b1;
                            req_ready      <= 1'b0;
                            ctrl_ena       <= 1'b0;
                            ctrl_sel_rst_n <= 1'b1;
                            state          <= DISABLE;
`ifdef TT_CTRL_INCREMENTAL_EN
                            if (cur_valid && req_addr >= cur_addr) begin
                                n_cnt <= req_addr - cur_addr;
                                skip  <= 1'b1;
                            end else begin
                                n_cnt <= req_addr;
                                skip  <= 1'b0;
                            end
`else
                            n_cnt <= req_addr;
                            skip  <= 1'b0;
`endif
                        end
                    end
                end
                DISABLE: begin
                    if (t_done) begin
                        if (!skip) begin
                            state          <= SELRST;
                            ctrl_sel_rst_n <= 1'b0;
                        end else if (n_cnt == '0) begin
                            state    <= ENABLE;
                            ctrl_ena <= 1'b1;
                        end else begin
                            state        <= INC_HI;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                end
                SELRST: begin
                    // Release the selector reset halfway through the state.
                    if (t_cnt == T_MID) begin
                        ctrl_sel_rst_n <= 1'b1;
                    end
                    if (t_done) begin
                        if (n_cnt == '0) begin
                            state    <= ENABLE;
                            ctrl_ena <= 1'b1;
                        end else begin
                            state        <= INC_HI;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                end
                INC_HI: begin
                    if (t_done) begin
                        state        <= INC_LO;
                        ctrl_sel_inc <= 1'b0;
                        n_cnt        <= n_cnt - ADDR_W'(1);
                    end
                end
                INC_LO: begin
                    if (t_done) begin
                        if (n_cnt == '0) begin
                            state    <= ENABLE;
                            ctrl_ena <= 1'b1;
                        end else begin
                            state        <= INC_HI;
                            ctrl_sel_inc <= 1'b1;
                        end
                    end
                end
                ENABLE: begin
                    if (t_done) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        req_ready <= 1'b1;
                        cur_addr  <= tgt;
                        cur_valid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tt_ctrl_sequencer.sv
// Directed bench for tt_ctrl_sequencer with a queue of expected sequences.
// A negedge monitor measures each sequence and a mux-selector model.
module tb_tt_ctrl_sequencer;

    localparam int AW  = 10;
    localparam int MAXA = 20;
    localparam int P   = 2;
    localparam int S   = 4;

    logic          clk;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          busy;
    logic          err;
    logic [AW-1:0] cur_addr;
    logic          cur_valid;
    logic          ctrl_ena;
    logic          ctrl_sel_inc;
    logic          ctrl_sel_rst_n;

    tt_ctrl_sequencer #(
        .ADDR_W        (AW),
        .MAX_ADDR      (MAXA),
        .PULSE_CYCLES  (P),
        .SETTLE_CYCLES (S)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_addr       (req_addr),
        .busy           (busy),
        .err            (err),
        .cur_addr       (cur_addr),
        .cur_valid      (cur_valid),
        .ctrl_ena       (ctrl_ena),
        .ctrl_sel_inc   (ctrl_sel_inc),
        .ctrl_sel_rst_n (ctrl_sel_rst_n)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int busy;
        int incs;
        int rstlow;
        int addr;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   m_cv  = 0;
    int   m_ca  = 0;

    task automatic chk(input string tag, input int obs, input int expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int addr);
        exp_t e;
        int   n;
        int   rl;
        n  = addr;
        rl = P;
`ifdef TT_CTRL_INCREMENTAL_EN
        if (m_cv != 0 && addr >= m_ca) begin
            n  = addr - m_ca;
            rl = 0;
        end
`endif
        e.busy   = 2 * S + 2 * rl + 2 * P * n;
        e.incs   = n;
        e.rstlow = rl;
        e.addr   = addr;
        return e;
    endfunction

    // Monitor state
    int p_ena, p_inc, p_srn, p_busy;
    int sel, bcnt, rises, rlow, hi, lo, seen_fall, nchg;
    exp_t got;

    initial begin
        p_ena = 0; p_inc = 0; p_srn = 0; p_busy = 0;
        sel = 0; bcnt = 0; rises = 0; rlow = 0;
        hi = 0; lo = 0; seen_fall = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                p_ena = 0; p_inc = 0; p_srn = 0; p_busy = 0;
                sel = 0;
            end else begin
                nchg = int'(ctrl_ena != p_ena[0]) +
                       int'(ctrl_sel_inc != p_inc[0]) +
                       int'(ctrl_sel_rst_n != p_srn[0]);
                chk("one_pin_per_edge", int'(nchg <= 1), 1);
                if (!ctrl_sel_rst_n) sel = 0;
                else if (ctrl_sel_inc && p_inc == 0) sel++;
                if (busy && p_busy == 0) begin
                    bcnt = 0; rises = 0; rlow = 0;
                    hi = 0; lo = 0; seen_fall = 0;
                end
                if (busy) begin
                    bcnt++;
                    if (!ctrl_sel_rst_n) rlow++;
                    if (ctrl_sel_inc && p_inc == 0) begin
                        rises++;
                        if (seen_fall != 0) chk("inc_low_len", lo, P);
                        lo = 0;
                    end
                    if (ctrl_sel_inc) hi++;
                    if (!ctrl_sel_inc && p_inc != 0) begin
                        chk("inc_high_len", hi, P);
                        hi = 0;
                        seen_fall = 1;
                        lo = 0;
                    end
                    if (ctrl_ena && p_ena == 0 && seen_fall != 0)
                        chk("last_low_len", lo, P);
                    if (!ctrl_sel_inc && !ctrl_ena && seen_fall != 0) lo++;
                end
                if (!busy && p_busy != 0) begin
                    chk("done_expected", int'(q.size() > 0), 1);
                    if (q.size() > 0) begin
                        got = q.pop_front();
                        chk("busy_cycles", bcnt, got.busy);
                        chk("inc_pulses", rises, got.incs);
                        chk("sel_rst_low", rlow, got.rstlow);
                        chk("cur_addr", int'(cur_addr), got.addr);
                        chk("cur_valid", int'(cur_valid), 1);
                        chk("ena_on", int'(ctrl_ena), 1);
                        chk("mux_model", sel, got.addr);
                    end
                end
                p_ena  = int'(ctrl_ena);
                p_inc  = int'(ctrl_sel_inc);
                p_srn  = int'(ctrl_sel_rst_n);
                p_busy = int'(busy);
            end
        end
    end

    task automatic wait_ready();
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        chk("ready_wait", int'(req_ready), 1);
    endtask

    task automatic send(input int addr);
        wait_ready();
        req_addr  = AW'(addr);
        req_valid = 1'b1;
        q.push_back(mk(addr));
        m_cv = 1;
        m_ca = addr;
        @(negedge clk);
        req_valid = 1'b0;
        chk("accept_busy", int'(busy), 1);
        chk("accept_no_err", int'(err), 0);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
        chk("seq_complete", q.size(), 0);
    endtask

    int snap_pins;
    int snap_addr;
    int snap_cv;

    initial begin
        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ena", int'(ctrl_ena), 0);
        chk("rst_inc", int'(ctrl_sel_inc), 0);
        chk("rst_srn", int'(ctrl_sel_rst_n), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_cv", int'(cur_valid), 0);
        chk("rst_ca", int'(cur_addr), 0);
        chk("rst_ready", int'(req_ready), 0);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_rst", int'(req_ready), 1);
        chk("srn_held_low", int'(ctrl_sel_rst_n), 0);

        // Basic selection, then address zero, then the top legal address
        send(3);
        wait_done();
        send(0);
        wait_done();
        send(MAXA);
        wait_done();

        // Out-of-range request
        wait_ready();
        snap_pins = {ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n};
        snap_addr = int'(cur_addr);
        snap_cv   = int'(cur_valid);
        req_addr  = AW'(MAXA + 1);
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        chk("err_pulse", int'(err), 1);
        chk("err_no_busy", int'(busy), 0);
        @(negedge clk);
        chk("err_one_cycle", int'(err), 0);
        chk("err_pins", int'({ctrl_ena, ctrl_sel_inc, ctrl_sel_rst_n}), snap_pins);
        chk("err_cur_addr", int'(cur_addr), snap_addr);
        chk("err_cur_valid", int'(cur_valid), snap_cv);
        chk("err_ready", int'(req_ready), 1);

        // Reset in the middle of an increment pulse
        send(5);
        for (int i = 0; i < 100 && !ctrl_sel_inc; i++) @(negedge clk);
        chk("inc_seen", int'(ctrl_sel_inc), 1);
        rst = 1'b1;
        #1;
        chk("mid_rst_inc", int'(ctrl_sel_inc), 0);
        chk("mid_rst_ena", int'(ctrl_ena), 0);
        chk("mid_rst_srn", int'(ctrl_sel_rst_n), 0);
        chk("mid_rst_cv", int'(cur_valid), 0);
        chk("mid_rst_busy", int'(busy), 0);
        q.delete();
        m_cv = 0;
        m_ca = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Request held through busy is taken once the first completes
        send(2);
        req_addr  = AW'(1);
        req_valid = 1'b1;
        q.push_back(mk(1));
        m_ca = 1;
        for (int i = 0; i < 100 && !req_ready; i++) @(negedge clk);
        chk("held_ready", int'(req_ready), 1);
        @(negedge clk);
        req_valid = 1'b0;
        chk("held_accepted", int'(busy), 1);
        wait_done();

        // Forward and backward steps (incremental when enabled)
        send(3);
        wait_done();
        send(5);
        wait_done();
        send(1);
        wait_done();

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
